button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Conditions one asynchronous push-button or software-GPIO level for use in the clk domain.
- Stage 1: a multi-flop synchronizer.
- Stage 2: a counter-based debouncer.
- Output is a clean, glitch-free level.
- Sits between raw board/PS inputs and FSM logic such as the LED sequencer.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops. Legal range >=2; elaboration error otherwise.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before the output changes (10 ms at 100 MHz). Legal range >=1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width. Derived; not user-set.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous level; may bounce or glitch.
- btn_sync  output  1  synchronized level (last synchronizer flop); not debounced.
- btn_out  output  1  debounced level.
- btn_rise  output  1  one-cycle pulse when btn_out goes 0->1.
- btn_fall  output  1  one-cycle pulse when btn_out goes 1->0.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - While rst=1 at a rising edge: all synchronizer flops, the counter, btn_out, btn_rise and btn_fall clear to 0.
  - Reset mid-count discards progress; the output stays 0 even if btn_in is high.
- Synchronizer:
  - Shift chain s[0..SYNC_STAGES-1], s[0] <= btn_in; btn_sync = s[SYNC_STAGES-1].
  - No combinational path from btn_in to any output.
- Debouncer, per cycle:
  - If btn_sync == btn_out: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_out <= btn_sync, counter <= 0.
  - Else: counter <= counter+1.
- Latency:
  - If btn_in is first sampled at edge 1 and then held, btn_out changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - The same latency applies to both polarities.
- Glitch rejection:
  - Any btn_sync return to btn_out before the count completes restarts the count from 0.
  - Pulses shorter than DEBOUNCE_CYCLES cycles (after synchronization) never reach btn_out.
- DEBOUNCE_CYCLES=1: btn_out follows btn_sync with exactly one cycle of delay.
- Counter never wraps; its maximum value is DEBOUNCE_CYCLES-1.
- Edge pulses (see Optional Feature):
  - btn_rise = btn_out & ~btn_out_q; btn_fall = ~btn_out & btn_out_q.
  - btn_out_q is btn_out delayed one cycle, reset to 0.
  - Pulses are registered-derived and last exactly one cycle; they are never both high.
  - No pulse is generated on reset release.

Optional Feature:
- Macro BUTTON_CONDITIONER_EDGE_EN.
- Defined: btn_out_q register present; btn_rise/btn_fall behave as above.
- Undefined: btn_out_q is not instantiated; btn_rise and btn_fall are tied to constant 0.
- Port list is identical in both builds.

Decomposition:
- Package button_conditioner_pkg holds:
  - default constants SYNC_STAGES_DEF=2 and DEBOUNCE_CYCLES_DEF=1000000;
  - a CLK_HZ reference constant of 100000000.
- One sub-module, btn_sync_chain:
  - parameter STAGES; ports clk, rst, d, q;
  - instantiated once for the synchronizer.
- Debounce counter and edge logic are inline in button_conditioner.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset: hold btn_in=1 with rst=1 for 10 cycles -> btn_sync, btn_out, btn_rise, btn_fall all 0. After release, btn_out=1 at the 6th edge; btn_rise high for exactly that one following cycle (EDGE_EN defined).
- Clean press: btn_in 0->1 sampled at edge 1 and held -> btn_sync=1 after edge 2; btn_out=1 after edge 6; btn_rise one-cycle pulse.
- Bounce: btn_in pattern 1,1,0,1,1,1,0 (one value per cycle), then held 1 -> btn_out stays 0 until 4 consecutive stable synchronized 1s, then goes 1. No btn_rise before that.
- Release: from btn_out=1, drive btn_in=0 and hold -> btn_out=0 after 6 edges; btn_fall pulses once; btn_rise stays 0.
- Short glitch rejection: with btn_out=0, pulse btn_in=1 for 3 cycles -> btn_out and btn_rise never assert.
- Build variants:
  - Without BUTTON_CONDITIONER_EDGE_EN: repeat clean press -> btn_out identical, btn_rise/btn_fall constant 0.
  - DEBOUNCE_CYCLES=1: btn_out trails btn_sync by exactly 1 cycle.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the button conditioner.
//   SYNC_STAGES_DEF     : default synchronizer depth
//   DEBOUNCE_CYCLES_DEF : default stable-cycle count (10 ms at CLK_HZ)
//   CLK_HZ              : reference system clock frequency
package button_conditioner_pkg;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CLK_HZ              = 100000000;

endpackage : button_conditioner_pkg

// File: rtl/btn_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : system clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input level
//   q   : synchronized level (last stage)
module btn_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("btn_sync_chain: STAGES must be >= 2");
  end

  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule : btn_sync_chain

// File: rtl/button_conditioner.sv
// Push-button / GPIO level conditioner: synchronizer followed by a
// counter-based debouncer, with optional one-cycle edge pulses.
// Edge pulses are enabled by defining BUTTON_CONDITIONER_EDGE_EN;
// otherwise btn_rise/btn_fall are tied low.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   btn_in   : raw asynchronous level
//   btn_sync : synchronized (not debounced) level
//   btn_out  : debounced level
//   btn_rise : one-cycle pulse on btn_out 0->1
//   btn_fall : one-cycle pulse on btn_out 1->0
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_sync,
  output logic btn_out,
  output logic btn_rise,
  output logic btn_fall
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  btn_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

  // Counter runs only while the synchronized level disagrees with the
  // output; any agreement restarts it, so it never exceeds CNT_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      btn_out <= 1'b0;
    end else if (btn_sync == btn_out) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt     <= '0;
      btn_out <= btn_sync;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef BUTTON_CONDITIONER_EDGE_EN
  logic btn_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_out_q <= 1'b0;
    end else begin
      btn_out_q <= btn_out;
    end
  end

  assign btn_rise = btn_out & ~btn_out_q;
  assign btn_fall = ~btn_out & btn_out_q;
`else
  assign btn_rise = 1'b0;
  assign btn_fall = 1'b0;
`endif

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;

  logic btn_sync, btn_out, btn_rise, btn_fall;
  logic btn_sync1, btn_out1, btn_rise1, btn_fall1;

  int checks = 0;
  int errors = 0;
  int rise_seen = 0;
  int fall_seen = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_sync (btn_sync),
    .btn_out  (btn_out),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  button_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_sync (btn_sync1),
    .btn_out  (btn_out1),
    .btn_rise (btn_rise1),
    .btn_fall (btn_fall1)
  );

  typedef struct {
    logic sync;
    logic out;
    logic rise;
    logic fall;
    logic out1;
    logic rise1;
    logic fall1;
  } exp_t;

  exp_t sb[$];

  // Bench model: two-stage sync pipe, debounced output flips once the
  // last DEB synchronized samples all disagree with it.
  logic m_s0 = 1'b0, m_s1 = 1'b0;
  logic m_out = 1'b0, m_out_q = 1'b0;
  logic m_out1 = 1'b0, m_out1_q = 1'b0;
  logic hist[$];

  task automatic model_edge(input logic b, input logic r);
    logic sync_pre;
    logic flip;
    sync_pre = m_s1;
    if (r) begin
      m_s0 = 1'b0; m_s1 = 1'b0;
      m_out = 1'b0; m_out_q = 1'b0;
      m_out1 = 1'b0; m_out1_q = 1'b0;
      hist.delete();
    end else begin
      hist.push_back(sync_pre);
      if (hist.size() > DEB) void'(hist.pop_front());
      flip = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] == m_out) flip = 1'b0;
      m_out_q  = m_out;
      m_out1_q = m_out1;
      if (flip) m_out = ~m_out;
      m_out1 = sync_pre;
      m_s1 = m_s0;
      m_s0 = b;
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    e.sync = m_s1;
    e.out  = m_out;
    e.out1 = m_out1;
`ifdef BUTTON_CONDITIONER_EDGE_EN
    e.rise  = m_out & ~m_out_q;
    e.fall  = ~m_out & m_out_q;
    e.rise1 = m_out1 & ~m_out1_q;
    e.fall1 = ~m_out1 & m_out1_q;
`else
    e.rise  = 1'b0;
    e.fall  = 1'b0;
    e.rise1 = 1'b0;
    e.fall1 = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input string what, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %b expected %b", tag, what, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, then sample #1
  // after the edge and compare against the popped expectation.
  task automatic step(input logic b, input logic r, input string tag);
    exp_t e;
    btn_in = b;
    rst    = r;
    @(posedge clk);
    model_edge(b, r);
    sb.push_back(model_expect());
    #1;
    e = sb.pop_front();
    chk(tag, "btn_sync",  btn_sync,  e.sync);
    chk(tag, "btn_out",   btn_out,   e.out);
    chk(tag, "btn_rise",  btn_rise,  e.rise);
    chk(tag, "btn_fall",  btn_fall,  e.fall);
    chk(tag, "btn_sync1", btn_sync1, e.sync);
    chk(tag, "btn_out1",  btn_out1,  e.out1);
    chk(tag, "btn_rise1", btn_rise1, e.rise1);
    chk(tag, "btn_fall1", btn_fall1, e.fall1);
    if (btn_rise === 1'b1) rise_seen++;
    if (btn_fall === 1'b1) fall_seen++;
  endtask

  task automatic phase_start();
    rise_seen = 0;
    fall_seen = 0;
  endtask

  int one_edge;

  initial begin
`ifdef BUTTON_CONDITIONER_EDGE_EN
    one_edge = 1;
`else
    one_edge = 0;
`endif

    // Reset held with button pressed: everything stays 0.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, "reset_hold");
    chk("reset_const", "btn_out", btn_out, 1'b0);
    chk("reset_const", "btn_sync", btn_sync, 1'b0);

    // Release reset with button held: output rises at the 6th edge.
    phase_start();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "post_reset_wait");
    chk("post_reset_edge5", "btn_out", btn_out, 1'b0);
    step(1'b1, 1'b0, "post_reset_edge6");
    chk("post_reset_edge6", "btn_out", btn_out, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "post_reset_hold");
    chk_int("post_reset_rise_count", rise_seen, one_edge);
    chk_int("post_reset_fall_count", fall_seen, 0);

    // Release: falls after 6 edges, one fall pulse, no rise.
    phase_start();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "release_wait");
    chk("release_edge5", "btn_out", btn_out, 1'b1);
    step(1'b0, 1'b0, "release_edge6");
    chk("release_edge6", "btn_out", btn_out, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "release_hold");
    chk_int("release_fall_count", fall_seen, one_edge);
    chk_int("release_rise_count", rise_seen, 0);

    // Clean press.
    phase_start();
    step(1'b1, 1'b0, "press_edge1");
    step(1'b1, 1'b0, "press_edge2");
    chk("press_edge2", "btn_sync", btn_sync, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "press_wait");
    chk("press_edge5", "btn_out", btn_out, 1'b0);
    step(1'b1, 1'b0, "press_edge6");
    chk("press_edge6", "btn_out", btn_out, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "press_hold");
    chk_int("press_rise_count", rise_seen, one_edge);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "press_release");

    // Bounce: 1,1,0,1,1,1,0 then held high.
    phase_start();
    begin
      logic [6:0] pat;
      pat = 7'b1101110;
      for (int i = 6; i >= 0; i--) step(pat[i], 1'b0, "bounce_pat");
    end
    chk_int("bounce_no_early_rise", rise_seen, 0);
    chk("bounce_out_low", "btn_out", btn_out, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "bounce_settle");
    chk("bounce_settled", "btn_out", btn_out, 1'b1);
    chk_int("bounce_rise_count", rise_seen, one_edge);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "bounce_release");

    // Short glitch: 3 cycles high never reaches the output.
    phase_start();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "glitch_high");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "glitch_low");
    chk_int("glitch_rise_count", rise_seen, 0);
    chk("glitch_out", "btn_out", btn_out, 1'b0);

    // Reset mid-count discards progress.
    phase_start();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "midreset_count");
    step(1'b1, 1'b1, "midreset_rst");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "midreset_wait");
    chk("midreset_edge5", "btn_out", btn_out, 1'b0);
    step(1'b1, 1'b0, "midreset_edge6");
    chk("midreset_edge6", "btn_out", btn_out, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "midreset_hold");

    // Random walk to exercise both instances against the model.
    for (int i = 0; i < 300; i++) begin
      logic b;
      b = ($urandom_range(0, 9) < 2) ? ~btn_in : btn_in;
      step(b, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, "random");
    end

    chk_int("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_button_conditioner
